uart_core: RTL and testbench

- Parametrised full-duplex UART for the vacuum-cleaner controller.
- Successor to the fixed 11-bit, factor-8 UART. Adds:
  - configurable data bits, stop bits and oversampling;
  - a fractional baud generator driven at runtime from clk_hz/baud_hz;
  - valid/ready TX handshake;
  - mid-bit majority-vote RX with start-glitch rejection and framing error.
- Sits between the sensor/motor command logic and the external serial link (Bluetooth or debug).

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_gen.sv | 40 ++++
 rtl/uart_core.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_core.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for uart_core: FSM state encoding and the RX sample-point
// offsets derived from the oversampling factor.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Three samples straddle the bit centre; the majority of them is the bit value.
    function automatic int unsigned samp_lo(input int unsigned ovs);
        return ovs / 2 - 1;
    endfunction

    function automatic int unsigned samp_mid(input int unsigned ovs);
        return ovs / 2;
    endfunction

    function automatic int unsigned samp_hi(input int unsigned ovs);
        return ovs / 2 + 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Fractional baud generator: one-clk tick at a mean rate of exactly OVS*baud_hz,
// derived from clk_hz with a wrap-and-subtract accumulator.
module uart_baud_gen #(
    parameter int OVS   = 16,
    parameter int ACC_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [28:0] clk_hz,
    input  logic [28:0] baud_hz,
    output logic        tick,
    output logic        baud_err
);

    logic [33:0]      inc_w;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    assign inc_w    = 34'(baud_hz) * 34'(OVS);
    assign baud_err = inc_w >= 34'(clk_hz);
    assign acc_d    = acc_q + ACC_W'(inc_w);

    // The accumulator is frozen while the ratio is illegal so no tick burst follows a fix.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            tick  <= 1'b0;
        end else if (baud_err) begin
            tick  <= 1'b0;
        end else if (acc_d >= ACC_W'(clk_hz)) begin
            // NOTE: flop state uses non-blocking assignments so every reader sees pre-edge values.
            acc_q <= acc_d - ACC_W'(clk_hz);
            tick  <= 1'b1;
        end else begin
            acc_q <= acc_d;
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_core.sv
// Parametrised full-duplex UART with fractional baud generation and majority-vote RX.
// Optional parity bit between data and stop bits when UART_PARITY_EN is defined.
module uart_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 2,
    parameter int OVS       = 16,
    parameter int ACC_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [28:0]          clk_hz,
    input  logic [28:0]          baud_hz,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_channel,
    output logic                 tx_busy,
    input  logic                 rx_channel,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy,
    output logic                 baud_err
`ifdef UART_PARITY_EN
    ,
    input  logic                 parity_odd,
    output logic                 rx_parity_err
`endif
);

`ifdef UART_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int NB    = DATA_BITS + PAR_BITS;
    localparam int CNT_W = $clog2(STOP_BITS * OVS);
    localparam int BIT_W = $clog2(NB);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(OVS - 1);
    localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_BITS * OVS - 1);
    localparam logic [CNT_W-1:0] S_LO     = CNT_W'(samp_lo(OVS));
    localparam logic [CNT_W-1:0] S_MID    = CNT_W'(samp_mid(OVS));
    localparam logic [CNT_W-1:0] S_HI     = CNT_W'(samp_hi(OVS));
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NB - 1);

    logic tick;

    uart_baud_gen #(.OVS(OVS), .ACC_W(ACC_W)) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clk_hz   (clk_hz),
        .baud_hz  (baud_hz),
        .tick     (tick),
        .baud_err (baud_err)
    );

    // ---------------- transmitter ----------------
    uart_state_e      tx_state_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [BIT_W-1:0] tx_bit_q;
    logic [NB-1:0]    tx_shift_q;
    logic [NB-1:0]    tx_word_d;
    logic             tx_channel_q;
    logic             tx_ready_q;

`ifdef UART_PARITY_EN
    assign tx_word_d = {^tx_data ^ parity_odd, tx_data};
`else
    assign tx_word_d = tx_data;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q   <= IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            tx_channel_q <= 1'b1;
            tx_ready_q   <= 1'b1;
        end else begin
            case (tx_state_q)
                IDLE: if (tx_valid && tx_ready_q) begin
                    tx_shift_q <= tx_word_d;
                    tx_ready_q <= 1'b0;
                    tx_cnt_q   <= '0;
                    tx_state_q <= START;
                end
                START: if (tick) begin
                    // A still-high line means this is the first tick: it opens the start bit.
                    if (tx_channel_q) begin
                        tx_channel_q <= 1'b0;
                        tx_cnt_q     <= '0;
                    end else if (tx_cnt_q == BIT_END) begin
                        tx_channel_q <= tx_shift_q[0];
                        tx_shift_q   <= tx_shift_q >> 1;
                        tx_bit_q     <= '0;
                        tx_cnt_q     <= '0;
                        tx_state_q   <= DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                DATA: if (tick) begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == LAST_BIT) begin
                            tx_channel_q <= 1'b1;
                            tx_state_q   <= STOP;
                        end else begin
                            tx_channel_q <= tx_shift_q[0];
                            tx_shift_q   <= tx_shift_q >> 1;
                            tx_bit_q     <= tx_bit_q + BIT_W'(1);
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                STOP: if (tick) begin
                    if (tx_cnt_q == STOP_END) begin
                        tx_ready_q <= 1'b1;
                        tx_state_q <= IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                default: tx_state_q <= IDLE;
            endcase
        end
    end

    assign tx_channel = tx_channel_q;
    assign tx_ready   = tx_ready_q;
    assign tx_busy    = tx_state_q != IDLE;

    // ---------------- receiver ----------------
    logic             rx_s1_q, rx_s2_q;
    uart_state_e      rx_state_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [BIT_W-1:0] rx_bit_q;
    logic [NB-1:0]    rx_shift_q;
    logic [1:0]       rx_votes_q;
    logic             rx_armed_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic             rx_valid_q;
    logic             rx_frame_err_q;
    logic             rx_maj;
`ifdef UART_PARITY_EN
    logic             rx_par_err_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rx_channel;
            rx_s2_q <= rx_s1_q;
        end
    end

    assign rx_maj = (rx_votes_q + {1'b0, rx_s2_q}) >= 2'd2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q     <= IDLE;
            rx_cnt_q       <= '0;
            rx_bit_q       <= '0;
            rx_shift_q     <= '0;
            rx_votes_q     <= '0;
            rx_armed_q     <= 1'b1;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_err_q   <= 1'b0;
`endif
        end else begin
            rx_valid_q <= 1'b0;
            if (tick) begin
                if (rx_state_q == IDLE) begin
                    // After a low stop bit (e.g. break) the line must go high before re-arming.
                    if (rx_s2_q) begin
                        rx_armed_q <= 1'b1;
                    end else if (rx_armed_q) begin
                        rx_state_q <= START;
                        rx_cnt_q   <= '0;
                        rx_votes_q <= '0;
                    end
                end else begin
                    rx_cnt_q <= (rx_cnt_q == BIT_END) ? '0 : rx_cnt_q + CNT_W'(1);
                    if (rx_cnt_q == S_LO || rx_cnt_q == S_MID)
                        rx_votes_q <= rx_votes_q + {1'b0, rx_s2_q};
                    if (rx_cnt_q == S_HI)
                        rx_votes_q <= '0;
                    case (rx_state_q)
                        START: begin
                            if (rx_cnt_q == S_HI && rx_maj) begin
                                rx_state_q <= IDLE;
                            end else if (rx_cnt_q == BIT_END) begin
                                rx_bit_q   <= '0;
                                rx_state_q <= DATA;
                            end
                        end
                        DATA: begin
                            if (rx_cnt_q == S_HI)
                                rx_shift_q <= {rx_maj, rx_shift_q[NB-1:1]};
                            if (rx_cnt_q == BIT_END) begin
                                if (rx_bit_q == LAST_BIT)
                                    rx_state_q <= STOP;
                                else
                                    rx_bit_q <= rx_bit_q + BIT_W'(1);
                            end
                        end
                        STOP: if (rx_cnt_q == S_HI) begin
                            rx_data_q      <= rx_shift_q[DATA_BITS-1:0];
                            rx_valid_q     <= 1'b1;
                            rx_frame_err_q <= !rx_maj;
`ifdef UART_PARITY_EN
                            rx_par_err_q   <= ^rx_shift_q ^ parity_odd;
`endif
                            rx_armed_q     <= rx_maj;
                            rx_state_q     <= IDLE;
                        end
                        default: rx_state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_frame_err_q;
    assign rx_busy      = rx_state_q != IDLE;
`ifdef UART_PARITY_EN
    assign rx_parity_err = rx_par_err_q;
`endif

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: TX waveform model, loopback and hand-driven RX frames,
// glitch/break/framing cases, baud generator rate and error, reset mid-frame.
module tb_uart_core;

    localparam int OVS_TB  = 16;
    localparam int CLK_HZ  = 320;
    localparam int BAUD_HZ = 10;
    localparam int BIT_CLK = CLK_HZ / BAUD_HZ;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FB = 1 + 8 + PB + 2;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [28:0] clk_hz, baud_hz;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready, tx_channel, tx_busy;
    logic        rx_line;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_frame_err, rx_busy, baud_err;
    logic        rx_drv;
    bit          loopback;
`ifdef UART_PARITY_EN
    logic        parity_odd_tb = 1'b0;
    logic        rx_parity_err;
`endif

    int   checks = 0;
    int   failures = 0;
    int   rx_valid_cnt = 0;
    exp_t exp_q[$];

    assign rx_line = loopback ? tx_channel : rx_drv;

    uart_core dut (
        .clk          (clk),
        .reset        (rst_n),
        .clk_hz       (clk_hz),
        .baud_hz      (baud_hz),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_channel   (tx_channel),
        .tx_busy      (tx_busy),
        .rx_channel   (rx_line),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy),
        .baud_err     (baud_err)
`ifdef UART_PARITY_EN
        ,
        .parity_odd   (parity_odd_tb),
        .rx_parity_err(rx_parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line level of bit k of a frame carrying d: start, data LSB first, [parity], stops.
    function automatic logic exp_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
`ifdef UART_PARITY_EN
        if (k == 9) return ^d ^ parity_odd_tb;
`endif
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rx_valid) begin
            rx_valid_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rx_unexpected actual=%0h expected=none", rx_data);
            end else begin
                e = exp_q.pop_front();
                check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                check("rx_frame_err", {31'd0, rx_frame_err}, {31'd0, e.ferr});
`ifdef UART_PARITY_EN
                check("rx_parity_err", {31'd0, rx_parity_err}, 32'd0);
`endif
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit expect_rx);
        int waited = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("tx_accept", {31'd0, tx_ready}, 32'd1);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        if (expect_rx) exp_q.push_back('{data: d, ferr: 1'b0});
    endtask

    task automatic wait_start(output int lat);
        lat = 0;
        while (tx_channel && lat < 2 * BIT_CLK) begin
            @(negedge clk);
            lat++;
        end
        check("tx_start_latency_ok", {31'd0, (lat <= BIT_CLK + 1) && !tx_channel}, 32'd1);
    endtask

    task automatic check_frame(input logic [7:0] d);
        int lat;
        wait_start(lat);
        check("tx_ready_busy", {30'd0, tx_ready, tx_busy}, 32'd1);
        for (int k = 0; k < FB; k++) begin
            repeat (k == 0 ? BIT_CLK / 2 : BIT_CLK) @(negedge clk);
            check($sformatf("tx_bit%0d", k), {31'd0, tx_channel}, {31'd0, exp_bit(d, k)});
        end
        repeat (BIT_CLK / 2 - 2) @(negedge clk);
        check("tx_ready_before_end", {31'd0, tx_ready}, 32'd0);
        repeat (4) @(negedge clk);
        check("tx_ready_after_end", {30'd0, tx_ready, tx_busy}, 32'd2);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop_lvl);
        for (int k = 0; k < FB; k++) begin
            rx_drv = (k == 9 + PB) ? stop_lvl : exp_bit(d, k);
            repeat (BIT_CLK) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 20 * BIT_CLK * FB) begin
            @(negedge clk);
            waited++;
        end
        check("rx_drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        #(80000 * 10);
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, busy, tc, low, v0;
        logic [7:0] b;
        rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; rx_drv = 1'b1; loopback = 1'b1;
        clk_hz = 29'(CLK_HZ); baud_hz = 29'(BAUD_HZ);
        repeat (3) @(negedge clk);
        check("rst_tx", {29'd0, tx_channel, tx_ready, tx_busy}, 32'd6);
        check("rst_rx", {21'd0, rx_data, rx_valid, rx_frame_err, rx_busy}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("baud_err_ok", {31'd0, baud_err}, 32'd0);

        send(8'hA5, 1'b1);
        check_frame(8'hA5);

        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h3C, 1'b1);
        for (int i = 0; i < 6; i++) send(8'($urandom_range(0, 255)), 1'b1);
        drain();
        repeat (3 * BIT_CLK) @(negedge clk);

        loopback = 1'b0;
        repeat (2 * BIT_CLK) @(negedge clk);
        v0 = rx_valid_cnt;
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        busy = 0;
        repeat (4 * BIT_CLK) begin
            @(negedge clk);
            if (rx_busy) busy++;
        end
        check("glitch_busy_bounded", {31'd0, busy > 0 && busy <= BIT_CLK}, 32'd1);
        check("glitch_no_valid", rx_valid_cnt - v0, 32'd0);

        exp_q.push_back('{data: 8'h55, ferr: 1'b1});
        drive_frame(8'h55, 1'b0);
        b = 8'($urandom_range(0, 255));
        exp_q.push_back('{data: b, ferr: 1'b0});
        drive_frame(b, 1'b1);
        drain();

        exp_q.push_back('{data: 8'h00, ferr: 1'b1});
        rx_drv = 1'b0;
        repeat (15 * BIT_CLK) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        b = 8'($urandom_range(0, 255));
        exp_q.push_back('{data: b, ferr: 1'b0});
        drive_frame(b, 1'b1);
        drain();

        clk_hz = 29'd100; baud_hz = 29'd7;
        repeat (2) @(negedge clk);
        check("baud_err_set", {31'd0, baud_err}, 32'd1);
        tx_data = 8'h81; tx_valid = 1'b1;
        tc = 0; low = 0;
        repeat (200) begin
            @(negedge clk);
            if (dut.u_baud.tick) tc++;
            if (!tx_channel) low++;
        end
        tx_valid = 1'b0;
        check("baud_err_no_tick", tc, 32'd0);
        check("baud_err_tx_idle_high", low, 32'd0);
        rst_n = 1'b0;
        baud_hz = 29'd3;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        tc = 0;
        repeat (100) begin
            @(negedge clk);
            if (dut.u_baud.tick) tc++;
        end
        check("tick_rate_48_per_100",
              {31'd0, (tc >= (100 * OVS_TB * 3) / 100 - 1) && (tc <= (100 * OVS_TB * 3) / 100 + 1)}, 32'd1);

        clk_hz = 29'(CLK_HZ); baud_hz = 29'(BAUD_HZ);
        loopback = 1'b1;
        repeat (10) @(negedge clk);
        v0 = rx_valid_cnt;
        send(8'hA5, 1'b0);
        wait_start(lat);
        repeat (3 * BIT_CLK + 8) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_tx_channel", {31'd0, tx_channel}, 32'd1);
        check("rst_mid_busy", {30'd0, tx_busy, rx_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_tx_ready", {31'd0, tx_ready}, 32'd1);
        repeat (FB * BIT_CLK) @(negedge clk);
        check("rst_mid_no_rx", rx_valid_cnt - v0, 32'd0);

`ifdef UART_PARITY_EN
        send(8'h07, 1'b1);
        check_frame(8'h07);
        drain();
`endif

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
